// File: rtl/mul_rs.sv
// mul_rs: multiply reservation station with CDB snooping and one-at-a-time dispatch.
// Define MUL_RS_OLDEST_FIRST_EN for oldest-ready dispatch; otherwise lowest-index ready wins.
module mul_rs #(
    parameter int         DEPTH      = 3,
    parameter logic [3:0] LABEL_BASE = 4'd4
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        issueEN,
    input  logic [2:0]  issueOp,
    input  logic [3:0]  issueQj,
    input  logic [31:0] issueVj,
    input  logic [3:0]  issueQk,
    input  logic [31:0] issueVk,
    output logic        full,
    output logic [3:0]  issueLabel,
    input  logic        cdbEN,
    input  logic [3:0]  cdbLabel,
    input  logic [31:0] cdbData,
    input  logic        EXEable,
    output logic        outEn,
    output logic [2:0]  opOut,
    output logic [31:0] dataOut1,
    output logic [31:0] dataOut2,
    output logic [3:0]  ready_labelOut
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic        busy_q[DEPTH], busy_d[DEPTH];
    logic [2:0]  op_q[DEPTH], op_d[DEPTH];
    logic [3:0]  qj_q[DEPTH], qj_d[DEPTH], qk_q[DEPTH], qk_d[DEPTH];
    logic [31:0] vj_q[DEPTH], vj_d[DEPTH], vk_q[DEPTH], vk_d[DEPTH];
    logic [IW-1:0] free_idx, sel;
    logic        found, byp_j, byp_k;
`ifdef MUL_RS_OLDEST_FIRST_EN
    logic [2:0]  age_q[DEPTH], age_d[DEPTH];
    logic [2:0]  best_age;
`endif
    always_comb begin
        full = 1'b1;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!busy_q[i]) begin
                full = 1'b0;
                free_idx = IW'(i);
            end
        found = 1'b0;
        sel = '0;
`ifdef MUL_RS_OLDEST_FIRST_EN
        best_age = '0;
        for (int i = 0; i < DEPTH; i++)
            if (busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0 && (!found || age_q[i] > best_age)) begin
                found = 1'b1;
                sel = IW'(i);
                best_age = age_q[i];
            end
`else
        for (int i = 0; i < DEPTH; i++)
            if (busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0 && !found) begin
                found = 1'b1;
                sel = IW'(i);
            end
`endif
    end
    assign issueLabel     = full ? 4'd0 : LABEL_BASE + 4'(free_idx);
    assign outEn          = found;
    assign opOut          = found ? op_q[sel] : 3'd0;
    assign dataOut1       = found ? vj_q[sel] : 32'd0;
    assign dataOut2       = found ? vk_q[sel] : 32'd0;
    assign ready_labelOut = found ? LABEL_BASE + 4'(sel) : 4'd0;
    assign byp_j = cdbEN && issueQj != '0 && issueQj == cdbLabel;
    assign byp_k = cdbEN && issueQk != '0 && issueQk == cdbLabel;
    always_comb begin
        busy_d = busy_q;
        op_d = op_q;
        qj_d = qj_q;
        vj_d = vj_q;
        qk_d = qk_q;
        vk_d = vk_q;
`ifdef MUL_RS_OLDEST_FIRST_EN
        age_d = age_q;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && cdbEN && cdbLabel != '0 && qj_q[i] == cdbLabel) begin
                qj_d[i] = '0;
                vj_d[i] = cdbData;
            end
            if (busy_q[i] && cdbEN && cdbLabel != '0 && qk_q[i] == cdbLabel) begin
                qk_d[i] = '0;
                vk_d[i] = cdbData;
            end
        end
        if (found && EXEable) busy_d[sel] = 1'b0;
        // the free entry is never busy, so issue cannot collide with dispatch or snoop
        if (issueEN && !full) begin
`ifdef MUL_RS_OLDEST_FIRST_EN
            for (int i = 0; i < DEPTH; i++)
                if (busy_q[i] && age_q[i] != 3'd7) age_d[i] = age_q[i] + 3'd1;
            age_d[free_idx] = '0;
`endif
            busy_d[free_idx] = 1'b1;
            op_d[free_idx] = issueOp;
            qj_d[free_idx] = byp_j ? 4'd0 : issueQj;
            vj_d[free_idx] = byp_j ? cdbData : issueVj;
            qk_d[free_idx] = byp_k ? 4'd0 : issueQk;
            vk_d[free_idx] = byp_k ? cdbData : issueVk;
        end
    end
    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                busy_q[i] <= 1'b0;
                op_q[i] <= '0;
                qj_q[i] <= '0;
                vj_q[i] <= '0;
                qk_q[i] <= '0;
                vk_q[i] <= '0;
`ifdef MUL_RS_OLDEST_FIRST_EN
                age_q[i] <= '0;
`endif
            end
        end else begin
            busy_q <= busy_d;
            op_q <= op_d;
            qj_q <= qj_d;
            vj_q <= vj_d;
            qk_q <= qk_d;
            vk_q <= vk_d;
`ifdef MUL_RS_OLDEST_FIRST_EN
            age_q <= age_d;
`endif
        end
    end
endmodule

// File: tb/tb_mul_rs.sv
// tb_mul_rs: directed bench for mul_rs; dispatched instructions are checked against a scoreboard queue.
module tb_mul_rs;
    logic        clk = 1'b0, RST = 1'b1;
    logic        issueEN = 1'b0, cdbEN = 1'b0, EXEable = 1'b0;
    logic [2:0]  issueOp = '0;
    logic [3:0]  issueQj = '0, issueQk = '0, cdbLabel = '0;
    logic [31:0] issueVj = '0, issueVk = '0, cdbData = '0;
    logic        full, outEn;
    logic [3:0]  issueLabel, ready_labelOut;
    logic [2:0]  opOut;
    logic [31:0] dataOut1, dataOut2;
    logic [70:0] sb[$];
    int errors = 0, checks = 0;

    mul_rs dut (
        .clk(clk), .RST(RST), .issueEN(issueEN), .issueOp(issueOp),
        .issueQj(issueQj), .issueVj(issueVj), .issueQk(issueQk), .issueVk(issueVk),
        .full(full), .issueLabel(issueLabel), .cdbEN(cdbEN), .cdbLabel(cdbLabel),
        .cdbData(cdbData), .EXEable(EXEable), .outEn(outEn), .opOut(opOut),
        .dataOut1(dataOut1), .dataOut2(dataOut2), .ready_labelOut(ready_labelOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] qj, input logic [31:0] vj,
                         input logic [3:0] qk, input logic [31:0] vk);
        issueEN = 1'b1;
        issueOp = op;
        issueQj = qj;
        issueVj = vj;
        issueQk = qk;
        issueVk = vk;
        tick();
        issueEN = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] lbl, input logic [31:0] d);
        cdbEN = 1'b1;
        cdbLabel = lbl;
        cdbData = d;
        tick();
        cdbEN = 1'b0;
    endtask

    // a handshake seen at the falling edge completes at the next rising edge
    always @(negedge clk) begin
        if (!RST && outEn && EXEable) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL dispatch_unexpected: observed label %0d expected none", ready_labelOut);
            end
            if (sb.size() > 0) begin
                logic [70:0] e;
                e = sb.pop_front();
                checks++;
                assert ({opOut, dataOut1, dataOut2, ready_labelOut} === e) else begin
                    errors++;
                    $error("FAIL dispatch: observed %0h expected %0h", {opOut, dataOut1, dataOut2, ready_labelOut}, e);
                end
            end
        end
    end

    initial begin
        tick();
        tick();
        RST = 1'b0;
        chk("reset_full", full, 0);
        chk("reset_label", issueLabel, 4);
        chk("reset_outs", {outEn, opOut, dataOut1, dataOut2, ready_labelOut}, 0);
        // ready-on-issue
        sb.push_back({3'd0, 32'd3, 32'd5, 4'd4});
        issue(3'd0, 4'd0, 32'd3, 4'd0, 32'd5);
        chk("t1_outen", outEn, 1);
        chk("t1_data", {dataOut1, dataOut2, ready_labelOut}, {32'd3, 32'd5, 4'd4});
        chk("t1_nextlabel", issueLabel, 5);
        EXEable = 1'b1;
        tick();
        chk("t1_freed", {outEn, full, issueLabel}, {1'b0, 1'b0, 4'd4});
        // operand arrives later on the CDB
        sb.push_back({3'd1, 32'h10, 32'd7, 4'd4});
        issue(3'd1, 4'd9, 32'd0, 4'd0, 32'd7);
        chk("t2_wait", outEn, 0);
        tick();
        chk("t2_wait2", outEn, 0);
        cdb(4'd9, 32'h10);
        chk("t2_ready", {outEn, dataOut1, dataOut2}, {1'b1, 32'h10, 32'd7});
        tick();
        chk("t2_done", outEn, 0);
        // issue-time bypass
        sb.push_back({3'd2, 32'h22, 32'h33, 4'd4});
        cdbEN = 1'b1;
        cdbLabel = 4'd9;
        cdbData = 32'h22;
        issue(3'd2, 4'd9, 32'd0, 4'd0, 32'h33);
        cdbEN = 1'b0;
        chk("t3_bypass", {outEn, dataOut1}, {1'b1, 32'h22});
        tick();
        chk("t3_done", outEn, 0);
        // fill the station, drop the overflow issue
        EXEable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_label", issueLabel, 4 + i);
            issue(3'(3 + i), 4'd12, 32'd0, 4'd0, 32'(i + 1));
        end
        chk("t4_full", {full, issueLabel, outEn}, {1'b1, 4'd0, 1'b0});
        issue(3'd6, 4'd0, 32'd1, 4'd0, 32'd1);
        chk("t4_dropped", outEn, 0);
        for (int i = 0; i < 3; i++) sb.push_back({3'(3 + i), 32'h40, 32'(i + 1), 4'(4 + i)});
        cdb(4'd12, 32'h40);
        chk("t4_first", {outEn, ready_labelOut}, {1'b1, 4'd4});
        EXEable = 1'b1;
        tick();
        tick();
        tick();
        chk("t4_drained", {outEn, full, issueLabel}, {1'b0, 1'b0, 4'd4});
        chk("t4_sb_empty", sb.size(), 0);
        // stall then reset
        EXEable = 1'b0;
        issue(3'd7, 4'd0, 32'hAAAA, 4'd0, 32'hBBBB);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold", {outEn, opOut, dataOut1, dataOut2, ready_labelOut}, {1'b1, 3'd7, 32'hAAAA, 32'hBBBB, 4'd4});
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("t5_reset", {outEn, opOut, dataOut1, dataOut2, ready_labelOut, full, issueLabel}, {1'b1 ^ 1'b1, 3'd0, 64'd0, 4'd0, 1'b0, 4'd4});
        // age ordering: idx2 older than re-issued idx0
        issue(3'd1, 4'd0, 32'hA0, 4'd0, 32'hA1);
        issue(3'd2, 4'd13, 32'd0, 4'd0, 32'hB1);
        issue(3'd3, 4'd0, 32'hC0, 4'd0, 32'hC1);
        sb.push_back({3'd1, 32'hA0, 32'hA1, 4'd4});
        EXEable = 1'b1;
        tick();
        EXEable = 1'b0;
        issue(3'd4, 4'd0, 32'hD0, 4'd0, 32'hD1);
`ifdef MUL_RS_OLDEST_FIRST_EN
        sb.push_back({3'd3, 32'hC0, 32'hC1, 4'd6});
        sb.push_back({3'd4, 32'hD0, 32'hD1, 4'd4});
`else
        sb.push_back({3'd4, 32'hD0, 32'hD1, 4'd4});
        sb.push_back({3'd3, 32'hC0, 32'hC1, 4'd6});
`endif
        EXEable = 1'b1;
        tick();
        tick();
        chk("t6_waiting", outEn, 0);
        sb.push_back({3'd2, 32'h55, 32'hB1, 4'd5});
        cdb(4'd13, 32'h55);
        tick();
        chk("t6_done", {outEn, full}, {1'b0, 1'b0});
        chk("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
